// File: rtl/vga_fb_pkg.sv
// Shared constants for the VGA framebuffer write controller: register map,
// STATUS bit positions, fill FSM encoding and framebuffer row pitch.
package vga_fb_pkg;

    localparam logic [2:0] REG_PIXEL     = 3'd0;
    localparam logic [2:0] REG_FILL_BASE = 3'd1;
    localparam logic [2:0] REG_FILL_SIZE = 3'd2;
    localparam logic [2:0] REG_FILL_CTRL = 3'd3;
    localparam logic [2:0] REG_STATUS    = 3'd4;
    localparam logic [2:0] REG_STATS     = 3'd5;

    localparam int ST_FIFO_EMPTY = 0;
    localparam int ST_FIFO_FULL  = 1;
    localparam int ST_FILL_BUSY  = 2;
    localparam int ST_OVERFLOW   = 3;

    localparam int ROW_PITCH = 256;
    localparam int ROW_SHIFT = $clog2(ROW_PITCH);

    typedef enum logic [0:0] {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending CPU pixel writes.
// Full/empty come from an occupancy counter; push to a full FIFO is refused.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == CNT_ZERO);
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; full is judged before the pop.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '{default: {WIDTH{1'b0}}};
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vga_fb_writer.sv
// CPU-side write controller sharing the framebuffer BRAM write port between a
// pixel FIFO and a rectangle-fill engine. Optional pixel counter: VGA_FB_WRITER_STATS_EN.
module vga_fb_writer
    import vga_fb_pkg::*;
#(
    parameter int FB_AW      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    input  logic             wstrb,
    output logic [31:0]      rdata,
    output logic             fb_en,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [7:0]       fb_wdata
);

    logic              wr_s, wr_pixel_s, wr_base_s, wr_size_s, wr_ctrl_s, wr_status_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [23:0]       fifo_head_s;
    logic              fill_req_s, grant_fifo_s, grant_fill_s;
    logic [23:0]       fill_lin_s;
    logic [FB_AW-1:0]  fill_addr_s;
    logic [3:0]        status_s;
    logic [7:0]        unused_wdata_s;

    fill_state_e       state_q, state_d;
    logic [15:0]       base_reg_q, base_reg_d;
    logic [7:0]        width_reg_q, width_reg_d;
    logic [7:0]        height_reg_q, height_reg_d;
    logic [15:0]       run_base_q, run_base_d;
    logic [7:0]        run_w_q, run_w_d;
    logic [7:0]        run_h_q, run_h_d;
    logic [7:0]        colour_q, colour_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic              overflow_q, overflow_d;
    logic              last_fifo_q, last_fifo_d;
    logic              fb_en_q, fb_en_d;
    logic              fb_we_q, fb_we_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
    logic [7:0]        fb_wdata_q, fb_wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    assign unused_wdata_s = wdata[31:24];

    assign wr_s        = valid & wstrb;
    assign wr_pixel_s  = wr_s & (addr == REG_PIXEL);
    assign wr_base_s   = wr_s & (addr == REG_FILL_BASE);
    assign wr_size_s   = wr_s & (addr == REG_FILL_SIZE);
    assign wr_ctrl_s   = wr_s & (addr == REG_FILL_CTRL);
    assign wr_status_s = wr_s & (addr == REG_STATUS);

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (wr_pixel_s),
        .push_data (wdata[23:0]),
        .pop       (grant_fifo_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Port arbitration: when both sources wait, take turns, FIFO first after a start.
    always_comb begin
        fill_req_s   = (state_q == FILL_RUN);
        grant_fifo_s = ~fifo_empty_s & (~fill_req_s | ~last_fifo_q);
        grant_fill_s = fill_req_s & ~grant_fifo_s;
        last_fifo_d  = fill_req_s & grant_fifo_s;
        fill_lin_s   = {8'h00, run_base_q} + ({16'h0000, y_q} << ROW_SHIFT) + {16'h0000, x_q};
        fill_addr_s  = FB_AW'(fill_lin_s);
    end

    // Bus-visible configuration and sticky overflow.
    always_comb begin
        base_reg_d   = base_reg_q;
        width_reg_d  = width_reg_q;
        height_reg_d = height_reg_q;
        overflow_d   = overflow_q;
        if (wr_base_s) begin
            base_reg_d = wdata[15:0];
        end else begin
            base_reg_d = base_reg_q;
        end
        if (wr_size_s) begin
            width_reg_d  = wdata[7:0];
            height_reg_d = wdata[15:8];
        end else begin
            width_reg_d  = width_reg_q;
            height_reg_d = height_reg_q;
        end
        if (wr_status_s && wdata[ST_OVERFLOW]) begin
            overflow_d = 1'b0;
        end else if (wr_pixel_s && fifo_full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Fill FSM: geometry is shadowed at start so later bus writes wait for the next fill.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        run_base_d = run_base_q;
        run_w_d    = run_w_q;
        run_h_d    = run_h_q;
        case (state_q)
            FILL_IDLE: begin
                if (wr_ctrl_s && wdata[8] && (width_reg_q != 8'd0) && (height_reg_q != 8'd0)) begin
                    state_d    = FILL_RUN;
                    x_d        = 8'd0;
                    y_d        = 8'd0;
                    colour_d   = wdata[7:0];
                    run_base_d = base_reg_q;
                    run_w_d    = width_reg_q;
                    run_h_d    = height_reg_q;
                end else begin
                    state_d = FILL_IDLE;
                end
            end
            FILL_RUN: begin
                if (grant_fill_s) begin
                    if (x_q == run_w_q - 8'd1) begin
                        x_d = 8'd0;
                        if (y_q == run_h_q - 8'd1) begin
                            state_d = FILL_IDLE;
                        end else begin
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end else begin
                    state_d = FILL_RUN;
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    // BRAM port drive, one cycle after the grant.
    always_comb begin
        fb_en_d    = grant_fifo_s | grant_fill_s;
        fb_we_d    = grant_fifo_s | grant_fill_s;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        if (grant_fifo_s) begin
            fb_addr_d  = FB_AW'(fifo_head_s[15:0]);
            fb_wdata_d = fifo_head_s[23:16];
        end else if (grant_fill_s) begin
            fb_addr_d  = fill_addr_s;
            fb_wdata_d = colour_q;
        end else begin
            fb_addr_d  = fb_addr_q;
            fb_wdata_d = fb_wdata_q;
        end
    end

`ifdef VGA_FB_WRITER_STATS_EN
    logic        wr_stats_s;
    logic [31:0] pixel_count_q, pixel_count_d;

    assign wr_stats_s = wr_s & (addr == REG_STATS);

    // Pixel counter: a clear wins over a same-cycle increment.
    always_comb begin
        if (wr_stats_s) begin
            pixel_count_d = 32'd0;
        end else if (fb_en_d) begin
            pixel_count_d = pixel_count_q + 32'd1;
        end else begin
            pixel_count_d = pixel_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pixel_count_q <= 32'd0;
        end else begin
            pixel_count_q <= pixel_count_d;
        end
    end
`endif

    // Read mux, sampled every clock regardless of valid.
    always_comb begin
        status_s                = 4'b0000;
        status_s[ST_FIFO_EMPTY] = fifo_empty_s;
        status_s[ST_FIFO_FULL]  = fifo_full_s;
        status_s[ST_FILL_BUSY]  = (state_q == FILL_RUN);
        status_s[ST_OVERFLOW]   = overflow_q;
        case (addr)
            REG_STATUS: rdata_d = {28'h0000000, status_s};
`ifdef VGA_FB_WRITER_STATS_EN
            REG_STATS:  rdata_d = pixel_count_q;
`endif
            default:    rdata_d = 32'h00000000;
        endcase
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= FILL_IDLE;
            base_reg_q   <= 16'h0000;
            width_reg_q  <= 8'h00;
            height_reg_q <= 8'h00;
            run_base_q   <= 16'h0000;
            run_w_q      <= 8'h00;
            run_h_q      <= 8'h00;
            colour_q     <= 8'h00;
            x_q          <= 8'h00;
            y_q          <= 8'h00;
            overflow_q   <= 1'b0;
            last_fifo_q  <= 1'b0;
            fb_en_q      <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= {FB_AW{1'b0}};
            fb_wdata_q   <= 8'h00;
            rdata_q      <= 32'h00000000;
        end else begin
            state_q      <= state_d;
            base_reg_q   <= base_reg_d;
            width_reg_q  <= width_reg_d;
            height_reg_q <= height_reg_d;
            run_base_q   <= run_base_d;
            run_w_q      <= run_w_d;
            run_h_q      <= run_h_d;
            colour_q     <= colour_d;
            x_q          <= x_d;
            y_q          <= y_d;
            overflow_q   <= overflow_d;
            last_fifo_q  <= last_fifo_d;
            fb_en_q      <= fb_en_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign fb_en    = fb_en_q;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Self-checking bench for vga_fb_writer: register table, directed corner cases and
// randomized pixel/fill traffic checked against a write-list model.
module tb_vga_fb_writer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        wstrb;
    logic [31:0] rdata;
    logic        fb_en, fb_we;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;

    vga_fb_writer #(.FB_AW(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .fb_en(fb_en), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t obs[$];
    wr_t exp_fill[$];
    wr_t exp_pix[$];

    always @(negedge clk) begin
        if (fb_en && fb_we) obs.push_back('{cyc, fb_addr, fb_wdata});
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        step();
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        valid = 1'b1; wstrb = 1'b0; addr = a;
        step();
        d = rdata;
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output logic [31:0] st);
        st = 32'hFFFFFFFF;
        for (int i = 0; i < limit; i++) begin
            bus_rd(3'd4, st);
            if (st[2:0] == 3'b001) break;
        end
        step();
        step();
        check("wait_idle", {29'd0, st[2:0]}, 32'h1);
    endtask

    // Model: raster order of a fill, addresses wrap modulo 2^16.
    task automatic build_fill(input int base, input int w, input int h, input logic [7:0] col);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_fill.push_back('{0, 16'((base + y * 256 + x) % 65536), col});
    endtask

    task automatic check_stream(input string nm, input logic [7:0] fmask, input logic [7:0] fval,
                                input bit use_pix);
        wr_t got[$];
        wr_t ex[$];
        int  mism;
        if (use_pix) ex = exp_pix; else ex = exp_fill;
        foreach (obs[i]) if ((obs[i].d & fmask) == fval) got.push_back(obs[i]);
        mism = 0;
        for (int i = 0; i < got.size() && i < ex.size(); i++)
            if (got[i].a !== ex[i].a || got[i].d !== ex[i].d) mism++;
        check({nm, "_count"}, got.size(), ex.size());
        check({nm, "_data"}, mism, 0);
    endtask

    typedef struct {
        bit          do_wr;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] st;
    int          c0, off_cyc, last_stamp, idx;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 3'd0, 32'h0,        3'd4, 32'h1};
        tbl[1] = '{1'b1, 3'd5, 32'h0,        3'd5, 32'h0};
        tbl[2] = '{1'b1, 3'd6, 32'hFFFFFFFF, 3'd6, 32'h0};
        tbl[3] = '{1'b0, 3'd0, 32'h0,        3'd7, 32'h0};
        tbl[4] = '{1'b1, 3'd4, 32'h8,        3'd4, 32'h1};
        tbl[5] = '{1'b1, 3'd4, 32'hFFFFFFFF, 3'd4, 32'h1};
        tbl[6] = '{1'b1, 3'd2, 32'h0,        3'd4, 32'h1};
        tbl[7] = '{1'b1, 3'd3, 32'h1AB,      3'd4, 32'h1};
        tbl[8] = '{1'b1, 3'd7, 32'h12345678, 3'd4, 32'h1};

        resetn = 1'b0; valid = 1'b0; wstrb = 1'b0; addr = 3'd0; wdata = 32'h0;
        step(); step();
        check("rst_fb_en", {31'd0, fb_en}, 32'h0);
        check("rst_fb_we", {31'd0, fb_we}, 32'h0);
        check("rst_fb_addr", {16'd0, fb_addr}, 32'h0);
        check("rst_fb_wdata", {24'd0, fb_wdata}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        resetn = 1'b1;
        step();
        obs.delete();

        // Register table
        foreach (tbl[i]) begin
            if (tbl[i].do_wr) bus_wr(tbl[i].wa, tbl[i].wd);
            bus_rd(tbl[i].ra, st);
            check($sformatf("table[%0d]", i), st, tbl[i].exp);
        end
        step(); step(); step();
        check("table_no_writes", obs.size(), 0);

        // Single pixel latency
        obs.delete();
        c0 = cyc;
        bus_wr(3'd0, 32'h00AA1234);
        repeat (4) step();
        check("pix_count", obs.size(), 1);
        if (obs.size() > 0) begin
            check("pix_latency", obs[0].stamp, c0 + 2);
            check("pix_addr", {16'd0, obs[0].a}, 32'h1234);
            check("pix_data", {24'd0, obs[0].d}, 32'hAA);
        end
        bus_rd(3'd4, st);
        check("pix_status", st, 32'h1);

        // Overflow: FIFO drained only every other cycle while a fill runs
        obs.delete(); exp_fill.delete(); exp_pix.delete();
        bus_wr(3'd1, 32'h4000);
        bus_wr(3'd2, 32'h1010);
        bus_wr(3'd3, 32'h133);
        build_fill(32'h4000, 16, 16, 8'h33);
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            bus_wr(3'd0, {8'h00, 8'h80 | 8'(i), 16'h0800 + 16'(i)});
            if (i < 7) exp_pix.push_back('{0, 16'h0800 + 16'(i), 8'h80 | 8'(i)});
        end
        bus_rd(3'd4, st);
        check("ovf_set", {31'd0, st[3]}, 32'h1);
        check("ovf_busy", {31'd0, st[2]}, 32'h1);
        bus_wr(3'd4, 32'h8);
        bus_rd(3'd4, st);
        check("ovf_clear", {31'd0, st[3]}, 32'h0);
        wait_idle(1000, st);
        check_stream("ovf_pix", 8'h80, 8'h80, 1'b1);
        check_stream("ovf_fill", 8'hFF, 8'h33, 1'b0);

`ifdef VGA_FB_WRITER_STATS_EN
        bus_wr(3'd5, 32'h0);
`endif
        // 3x2 fill and busy drop timing
        obs.delete(); exp_fill.delete();
        bus_wr(3'd1, 32'h0100);
        bus_wr(3'd2, 32'h0203);
        bus_wr(3'd3, 32'h155);
        build_fill(32'h0100, 3, 2, 8'h55);
        off_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            bus_rd(3'd4, st);
            if (!st[2]) begin off_cyc = cyc; break; end
        end
        step(); step();
        check("fill6_total", obs.size(), 6);
        check_stream("fill6", 8'hFF, 8'h55, 1'b0);
        last_stamp = (obs.size() > 0) ? obs[obs.size() - 1].stamp : -100;
        check("fill6_busy_drop", off_cyc, last_stamp + 1);
`ifdef VGA_FB_WRITER_STATS_EN
        bus_wr(3'd0, 32'h00C10020);
        wait_idle(50, st);
        bus_rd(3'd5, st);
        check("stats_count", st, 32'd7);
`endif

        // Alternation; base/ctrl writes during the run must not disturb it
        obs.delete(); exp_fill.delete();
        bus_wr(3'd1, 32'h2000);
        bus_wr(3'd2, 32'h0404);
        bus_wr(3'd3, 32'h111);
        build_fill(32'h2000, 4, 4, 8'h11);
        repeat (3) step();
        bus_wr(3'd0, 32'h00770010);
        bus_wr(3'd1, 32'h3000);
        bus_wr(3'd3, 32'h1EE);
        wait_idle(100, st);
        check_stream("alt_fill", 8'hFF, 8'h11, 1'b0);
        check("alt_total", obs.size(), 17);
        idx = -1;
        foreach (obs[i]) if (obs[i].a == 16'h0010 && obs[i].d == 8'h77) idx = i;
        check("alt_pix_found", {31'd0, idx > 0 && idx < obs.size() - 1}, 32'h1);
        if (idx > 0 && idx < obs.size() - 1) begin
            check("alt_prev_fill", {24'd0, obs[idx - 1].d}, 32'h11);
            check("alt_next_fill", {24'd0, obs[idx + 1].d}, 32'h11);
            check("alt_back_to_back", obs[idx + 1].stamp - obs[idx - 1].stamp, 2);
        end

        // Address wrap, then zero-width start
        obs.delete();
        bus_wr(3'd1, 32'hFFFF);
        bus_wr(3'd2, 32'h0102);
        bus_wr(3'd3, 32'h1A5);
        wait_idle(50, st);
        check("wrap_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("wrap_first", {16'd0, obs[0].a}, 32'hFFFF);
            check("wrap_second", {16'd0, obs[1].a}, 32'h0000);
        end
        obs.delete();
        bus_wr(3'd2, 32'h0300);
        bus_wr(3'd3, 32'h1A5);
        bus_rd(3'd4, st);
        check("zero_w_busy", st, 32'h1);
        repeat (10) step();
        check("zero_w_writes", obs.size(), 0);

        // Reset in the middle of a 16x16 fill
        bus_wr(3'd1, 32'h5000);
        bus_wr(3'd2, 32'h1010);
        bus_wr(3'd3, 32'h1C3);
        repeat (20) step();
        addr = 3'd4;
        resetn = 1'b0;
        step();
        check("midrst_fb_we", {31'd0, fb_we}, 32'h0);
        check("midrst_fb_addr", {16'd0, fb_addr}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        resetn = 1'b1;
        obs.delete();
        step();
        check("midrst_status", rdata, 32'h1);
        repeat (30) step();
        check("midrst_no_writes", obs.size(), 0);

        // Randomized traffic against the write-list model
        for (int it = 0; it < 30; it++) begin
            obs.delete(); exp_fill.delete(); exp_pix.delete();
            if ($urandom_range(0, 1) == 0) begin
                int n;
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) begin
                    logic [15:0] a;
                    logic [7:0]  c;
                    a = 16'($urandom);
                    c = 8'h80 | 8'($urandom_range(0, 127));
                    bus_wr(3'd0, {8'h00, c, a});
                    exp_pix.push_back('{0, a, c});
                    if ($urandom_range(0, 1) == 1) step();
                end
            end else begin
                int          base, w, h, k;
                logic [7:0]  col;
                base = $urandom_range(0, 65535);
                w    = $urandom_range(0, 6);
                h    = $urandom_range(0, 4);
                col  = 8'($urandom_range(0, 127));
                bus_wr(3'd1, 32'(base));
                bus_wr(3'd2, {16'h0, 8'(h), 8'(w)});
                bus_wr(3'd3, {23'h0, 1'b1, col});
                build_fill(base, w, h, col);
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) begin
                    logic [15:0] a;
                    logic [7:0]  c;
                    repeat ($urandom_range(0, 3)) step();
                    a = 16'($urandom);
                    c = 8'h80 | 8'($urandom_range(0, 127));
                    bus_wr(3'd0, {8'h00, c, a});
                    exp_pix.push_back('{0, a, c});
                end
            end
            wait_idle(200, st);
            check($sformatf("rand%0d_status", it), st, 32'h1);
            check_stream($sformatf("rand%0d_pix", it), 8'h80, 8'h80, 1'b1);
            check_stream($sformatf("rand%0d_fill", it), 8'h80, 8'h00, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
